// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter.
// Pops one byte at a time into a held output register and hands it over
// with a registered tx_ready request. It waits for the transmitter to
// acknowledge (tx_bits_ok falls) and then for it to reach STOP/IDLE again.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for data and a free transmitter; pops the head byte
// LOAD  | byte latched in tx_data_o, request still low
// REQ   | tx_ready high, waiting for the transmitter to start a frame
// BUSY  | frame in progress, waiting for the transmitter to reach STOP
module uart_tx_feeder #(
  parameter int AW = 4
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          tx_ready,
  output logic [7:0]    tx_data_o,
  input  logic          tx_bits_ok,
  output logic [15:0]   sent_cnt
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0]   DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_REQ, ST_BUSY} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          tx_ready_q, tx_ready_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [15:0]   sent_cnt_q, sent_cnt_d;
  logic          pop, push, drop;

  // Occupancy flags decoded straight from the count.
  always_comb begin
    full  = (count_q == DEPTH_C);
    empty = (count_q == '0);
  end

  // State register plus all datapath flops.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
      sent_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_ready_q <= tx_ready_d;
      tx_data_q  <= tx_data_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Next-state logic: handshake with the transmitter's tx_bits_ok.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!empty && tx_bits_ok) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_REQ;
      ST_REQ:  if (!tx_bits_ok) state_d = ST_BUSY;
      ST_BUSY: if (tx_bits_ok) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic: pop/push arbitration, counters, flags.
  always_comb begin
    pop  = (state_q == ST_IDLE) && !empty && tx_bits_ok;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push = wr_en && (!full || pop);
    drop = wr_en && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;

    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    // Registered request: high exactly while the FSM sits in REQ.
    tx_ready_d = (state_d == ST_REQ);
    sent_cnt_d = ((state_q == ST_REQ) && !tx_bits_ok) ? sent_cnt_q + 16'd1 : sent_cnt_q;
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_ready  = tx_ready_q;
  assign tx_data_o = tx_data_q;
  assign sent_cnt  = sent_cnt_q;

endmodule
